// File: rtl/ram_copy_engine.sv
// ram_copy_engine
// Copies a block of words inside a single-port synchronous RAM by issuing one
// read access followed by one write access per word (2 cycles per word).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | bus idle, waiting for start
//   RD    | read access at src pointer (RAM registers data on closing edge)
//   WR    | write access at dst pointer with the word read in RD
//   FIN   | one-cycle done pulse, start ignored
//
// Ports:
//   clk, reset_b                 clock, asynchronous active-low reset
//   start, src_addr, dst_addr, len  copy request (sampled only in IDLE)
//   busy, done                   status (done is a one-cycle pulse)
//   ram_address, ram_din, ram_rnw, ram_cs_b  RAM initiator port
//   ram_dout                     registered RAM read data
module ram_copy_engine #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int LW = 14
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_rnw,
    output logic          ram_cs_b
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cs_b_q, cs_b_d;
    logic          rnw_q, rnw_d;
    logic [AW-1:0] addr_q, addr_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_b_q  <= 1'b1;
            rnw_q   <= 1'b1;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_b_q  <= cs_b_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
        end
    end

    // Next state and pointer/count updates. Pointers wrap naturally at 2^AW.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = S_RD;
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = (len > MAX_LEN) ? MAX_LEN : len;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD: begin
                src_d   = src_q + AW'(1);
                state_d = S_WR;
            end
            S_WR: begin
                dst_d   = dst_q + AW'(1);
                cnt_d   = cnt_q - LW'(1);
                state_d = (cnt_q == LW'(1)) ? S_FIN : S_RD;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state and
    // the upcoming pointer values. The address holds its last value when idle.
    always_comb begin
        busy_d = (state_d == S_RD) || (state_d == S_WR);
        done_d = (state_d == S_FIN);
        cs_b_d = !busy_d;
        rnw_d  = (state_d != S_WR);
        addr_d = addr_q;
        if (state_d == S_RD) begin
            addr_d = src_d;
        end else if (state_d == S_WR) begin
            addr_d = dst_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_cs_b    = cs_b_q;
    assign ram_rnw     = rnw_q;
    assign ram_address = addr_q;
    assign ram_din     = ram_dout;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Testbench for ram_copy_engine: a behavioural 8192x32 RAM on the bus, and a
// reference copy model working on a plain array with word-by-word ascending
// copy semantics.
module tb_ram_copy_engine;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LW = 14;
    localparam int NW = 8192;

    logic          clk;
    logic          reset_b;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_rnw;
    logic          ram_cs_b;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] img     [NW];
    logic [DW-1:0] ref_mem [NW];
    logic          load;

    ram_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_rnw     (ram_rnw),
        .ram_cs_b    (ram_cs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM; load copies the whole preload image in one edge.
    always @(posedge clk) begin
        if (load) begin
            mem <= img;
        end else if (!ram_cs_b) begin
            if (ram_rnw) ram_dout <= mem[ram_address];
            else         mem[ram_address] <= ram_din;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic randomize_img();
        for (int i = 0; i < NW; i++) img[i] = $urandom;
    endtask

    task automatic commit_img();
        for (int i = 0; i < NW; i++) ref_mem[i] = img[i];
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== ref_mem[i]) nbad++;
        check(tag, nbad, 0);
    endtask

    // Issue one copy, check every bus cycle against the expected RD/WR address
    // sequence, the busy window, the done pulse position, and final memory.
    task automatic run_copy(input string tag, input int s, input int d, input int l,
                            input bit noise);
        int L, bus_bad, first_bad, busy_n, done_n, done_at;
        logic          e_cs_b, e_rnw, e_busy, e_done, chk_addr;
        logic [AW-1:0] e_addr;
        L = (l > NW) ? NW : l;
        for (int i = 0; i < L; i++)
            ref_mem[(d + i) % NW] = ref_mem[(s + i) % NW];
        @(negedge clk);
        start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); len = LW'(l);
        bus_bad = 0; first_bad = 0; busy_n = 0; done_n = 0; done_at = 0;
        for (int k = 1; k <= 2 * L + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk_addr = 1'b0;
            e_addr   = '0;
            if (k <= 2 * L) begin
                e_cs_b = 1'b0; e_busy = 1'b1; e_done = 1'b0; chk_addr = 1'b1;
                e_rnw  = (k % 2) == 1;
                e_addr = e_rnw ? AW'(s + (k - 1) / 2) : AW'(d + (k - 1) / 2);
            end else if (k == 2 * L + 1) begin
                e_cs_b = 1'b1; e_rnw = 1'b1; e_busy = 1'b0; e_done = 1'b1;
            end else begin
                e_cs_b = 1'b1; e_rnw = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end
            if (ram_cs_b !== e_cs_b || ram_rnw !== e_rnw || busy !== e_busy ||
                done !== e_done || (chk_addr && ram_address !== e_addr)) begin
                bus_bad++;
                if (first_bad == 0) first_bad = k;
            end
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = k; end
            if (noise && (k <= 2 * L + 1) && ($urandom_range(0, 2) == 0 || k == 2 * L + 1)) begin
                start = 1'b1;
                src_addr = AW'($urandom); dst_addr = AW'($urandom); len = LW'($urandom);
            end
        end
        check({tag, "_bus_first_bad_cycle"}, first_bad, 0);
        check({tag, "_busy_cycles"}, busy_n, 2 * L);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_cycle"}, done_at, 2 * L + 1);
        check_mem({tag, "_mem_bad_words"});
    endtask

    initial begin
        int s, d;
        load = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        reset_b = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs_b", ram_cs_b, 1);
        check("rst_rnw", ram_rnw, 1);
        check("rst_addr", ram_address, 0);
        @(negedge clk);
        reset_b = 1'b1;

        // Basic 4-word copy
        randomize_img();
        for (int i = 0; i < 4; i++) img[16 + i] = 32'hA0 + i;
        commit_img();
        run_copy("basic", 16'h0010, 16'h0100, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("basic_dst_word", mem[256 + i], 32'hA0 + i);

        // Zero length: done only, no bus activity
        run_copy("len0", 5, 9, 0, 1'b0);

        // Address wrap with overlap onto the wrapped source
        randomize_img();
        img[13'h1FFE] = 1; img[13'h1FFF] = 2; img[0] = 3; img[1] = 4;
        commit_img();
        run_copy("wrap", 13'h1FFE, 0, 4, 1'b0);
        check("wrap_w0", mem[0], 1);
        check("wrap_w1", mem[1], 2);
        check("wrap_w2", mem[2], 1);
        check("wrap_w3", mem[3], 2);

        // Ignored start during busy and FIN
        run_copy("ignore", 100, 3000, 6, 1'b1);

        // Randomized copies, some overlapping forward or backward
        for (int t = 0; t < 12; t++) begin
            randomize_img();
            commit_img();
            s = $urandom_range(0, NW - 1);
            case (t % 3)
                0: d = $urandom_range(0, NW - 1);
                1: d = (s + $urandom_range(1, 10)) % NW;
                default: d = (s + NW - $urandom_range(1, 10)) % NW;
            endcase
            run_copy("rand", s, d, $urandom_range(1, 40), t[0]);
        end

        // Reset during the 3rd WR cycle of an 8-word copy
        randomize_img();
        commit_img();
        s = $urandom_range(0, NW - 1);
        d = (s + 1000) % NW;
        for (int i = 0; i < 2; i++) ref_mem[(d + i) % NW] = ref_mem[(s + i) % NW];
        @(negedge clk);
        start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); len = LW'(8);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_is_wr", {ram_cs_b, ram_rnw}, 2'b00);
        reset_b = 1'b0;
        #1;
        check("midrst_cs_b", ram_cs_b, 1);
        check("midrst_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_done", {done, ram_cs_b}, 2'b01);
        end
        reset_b = 1'b1;
        check_mem("midrst_mem_bad_words");
        run_copy("after_rst", $urandom_range(0, NW - 1), $urandom_range(0, NW - 1), 5, 1'b0);

        // Full-size in-place copy and a clamped oversize length
        run_copy("full", 0, 0, 8192, 1'b0);
        run_copy("clamp", 5, 5, 10000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
